// File: rtl/interval_timer.sv
// Programmable interval timer: loads a tick count from one of four writable
// parameters and returns a one-cycle expired pulse. Optional hold port: TIMER_HOLD_EN.
module interval_timer #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned T_BASE   = 6,
  parameter int unsigned T_EXT    = 3,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_WALK   = 4
) (
  input  logic       clk,
  input  logic       g_reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       prog_sync,
  input  logic [1:0] prog_sel,
  input  logic [3:0] prog_value,
`ifdef TIMER_HOLD_EN
  input  logic       hold,
`endif
  output logic       expired,
  output logic       busy,
  output logic [3:0] time_left
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    param_q [4];
  logic [3:0]    param_d [4];
  logic          expired_q, busy_q;
  logic          freeze;

`ifdef TIMER_HOLD_EN
  assign freeze = hold;
`else
  assign freeze = 1'b0;
`endif

  function automatic logic [3:0] param_default(input logic [1:0] idx);
    logic [3:0] val;
    case (idx)
      2'd0:    val = 4'(T_BASE);
      2'd1:    val = 4'(T_EXT);
      2'd2:    val = 4'(T_YEL);
      default: val = 4'(T_WALK);
    endcase
    return val;
  endfunction

  // Writes land in param_q after the edge, so a same-edge load sees the old value.
  always_comb begin
    for (int i = 0; i < 4; i++) param_d[i] = param_q[i];
    if (prog_sync) begin
      param_d[prog_sel] = (prog_value == 4'd0) ? param_default(prog_sel) : prog_value;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    if (start_timer) begin
      state_d = StRun;
      presc_d = '0;
      count_d = param_q[interval];
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StRun: begin
          if (!freeze) begin
            if (presc_q == PrescLast) begin
              presc_d = '0;
              if (count_q <= 4'd1) begin
                state_d = StDone;
                count_d = 4'd0;
              end else begin
                count_d = count_q - 4'd1;
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (g_reset) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      count_q   <= 4'd0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < 4; i++) param_q[i] <= param_default(2'(i));
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      expired_q <= (state_d == StDone);
      busy_q    <= (state_d == StRun);
      for (int i = 0; i < 4; i++) param_q[i] <= param_d[i];
    end
  end

  assign expired   = expired_q;
  assign busy      = busy_q;
  assign time_left = count_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed and random checks of interval_timer against a time-based model:
// an interval started at edge k with N ticks expires after exactly N*TICK_DIV edges.
module tb_interval_timer;

  localparam int TD = 4;
  localparam int DEFS [4] = '{6, 3, 2, 4};

  logic       clk = 1'b0;
  logic       g_reset = 1'b0;
  logic       start_timer = 1'b0;
  logic [1:0] interval = 2'd0;
  logic       prog_sync = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic [3:0] prog_value = 4'd0;
  logic       hold = 1'b0;
  logic       expired, busy;
  logic [3:0] time_left;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: elapsed active edges since the load, and the parameter table.
  bit m_run = 1'b0, m_done = 1'b0;
  int m_n = 0, m_elapsed = 0;
  int m_param [4] = '{6, 3, 2, 4};

  interval_timer #(
    .TICK_DIV(TD), .T_BASE(6), .T_EXT(3), .T_YEL(2), .T_WALK(4)
  ) dut (
    .clk        (clk),
    .g_reset    (g_reset),
    .start_timer(start_timer),
    .interval   (interval),
    .prog_sync  (prog_sync),
    .prog_sel   (prog_sel),
    .prog_value (prog_value),
`ifdef TIMER_HOLD_EN
    .hold       (hold),
`endif
    .expired    (expired),
    .busy       (busy),
    .time_left  (time_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_edge();
    int old_param [4];
    bit h;
    old_param = m_param;
`ifdef TIMER_HOLD_EN
    h = hold;
`else
    h = 1'b0;
`endif
    if (g_reset) begin
      m_run = 1'b0; m_done = 1'b0; m_n = 0; m_elapsed = 0;
      m_param = DEFS;
    end else begin
      if (start_timer) begin
        m_run = 1'b1; m_done = 1'b0; m_n = old_param[interval]; m_elapsed = 0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_run) begin
        if (!h) m_elapsed++;
        if (m_elapsed == m_n * TD) begin
          m_run = 1'b0; m_done = 1'b1;
        end
      end
      if (prog_sync) m_param[prog_sel] = (prog_value == 0) ? DEFS[prog_sel] : int'(prog_value);
    end
  endtask

  // One clock edge: update model with the sampled inputs, check outputs, clear pulses.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("expired", int'(expired), int'(m_done));
    check("busy", int'(busy), int'(m_run));
    check("time_left", int'(time_left), m_run ? (m_n - m_elapsed / TD) : 0);
    start_timer = 1'b0;
    prog_sync = 1'b0;
    g_reset = 1'b0;
  endtask

  task automatic start(input logic [1:0] code);
    start_timer = 1'b1;
    interval = code;
    step();
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    prog_sync = 1'b1;
    prog_sel = sel;
    prog_value = val;
  endtask

  // Edges from the load edge until expired is seen, bounded by max.
  task automatic wait_expired(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!expired && n < max);
  endtask

  int cyc;

  initial begin
    // Reset held two cycles
    g_reset = 1'b1; step();
    g_reset = 1'b1; step();
    check("rst_expired", int'(expired), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_time_left", int'(time_left), 0);

    // Every default readable through a load
    for (int i = 0; i < 4; i++) begin
      start(2'(i));
      wait_expired(100, cyc);
      check("default_len", cyc, DEFS[i] * TD);
      step();
    end

    repeat (3) step();
    start(2'd0);
    wait_expired(100, cyc);
    check("base_len", cyc, 24);
    step();
    check("busy_after", int'(busy), 0);

    // Reprogram yellow then restore default
    prog(2'd2, 4'd5); step();
    start(2'd2);
    wait_expired(100, cyc);
    check("prog_len", cyc, 20);
    step();
    prog(2'd2, 4'd0); step();
    start(2'd2);
    wait_expired(100, cyc);
    check("restore_len", cyc, 8);
    step();

    // Same-edge write and load on one index: load takes old value
    prog(2'd1, 4'd7);
    start(2'd1);
    wait_expired(100, cyc);
    check("same_edge_len", cyc, 12);
    step();
    start(2'd1);
    wait_expired(100, cyc);
    check("new_val_len", cyc, 28);
    step();

    // Retrigger mid-run
    start(2'd0);
    repeat (9) step();
    start(2'd2);
    wait_expired(100, cyc);
    check("retrig_len", cyc, 8);
    repeat (20) step();

    // Start during DONE: pulse completes, then fresh run
    start(2'd3);
    wait_expired(100, cyc);
    start(2'd2);
    check("done_restart_busy", int'(busy), 1);
    wait_expired(100, cyc);
    check("done_restart_len", cyc, 8);
    step();

    // Reset mid-run restores defaults and suppresses the pulse
    prog(2'd0, 4'd9); step();
    start(2'd0);
    repeat (9) step();
    g_reset = 1'b1; step();
    repeat (30) step();
    start(2'd0);
    wait_expired(100, cyc);
    check("post_rst_len", cyc, 24);
    step();

`ifdef TIMER_HOLD_EN
    start(2'd1);
    repeat (3) step();
    hold = 1'b1;
    repeat (10) step();
    hold = 1'b0;
    wait_expired(100, cyc);
    check("hold_len", cyc + 13, 22);
    step();
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      start_timer = ($urandom_range(0, 11) == 0);
      interval    = 2'($urandom_range(0, 3));
      prog_sync   = ($urandom_range(0, 7) == 0);
      prog_sel    = 2'($urandom_range(0, 3));
      prog_value  = 4'($urandom_range(0, 15));
      g_reset     = ($urandom_range(0, 149) == 0);
`ifdef TIMER_HOLD_EN
      hold        = ($urandom_range(0, 5) == 0);
`endif
      step();
    end
    hold = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
